// File: rtl/sin_lut_pkg.sv
// Shared constants and types for the quarter-wave sine LUT arbiter.
package sin_lut_pkg;

    localparam int unsigned QW_DEPTH  = 900;
    localparam int unsigned PHASE_W   = 12;
    localparam int unsigned PHASE_MAX = 4 * QW_DEPTH;
    localparam int unsigned OFFSET    = 16384;

    // Quadrant boundaries on the full-circle phase index
    localparam int unsigned FOLD_B1 = 900;
    localparam int unsigned FOLD_B2 = 1800;
    localparam int unsigned FOLD_B3 = 2700;

    typedef enum logic [1:0] {
        QD0 = 2'd0,
        QD1 = 2'd1,
        QD2 = 2'd2,
        QD3 = 2'd3
    } quadrant_t;

endpackage

// File: rtl/sin_lut_arbiter_phase_fold.sv
// Folds a full-circle phase index into quadrant plus quarter-wave ROM address.
module phase_fold
    import sin_lut_pkg::*;
#(
    parameter int unsigned ADDR_W = 11,
    parameter int unsigned B1     = FOLD_B1,
    parameter int unsigned B2     = FOLD_B2,
    parameter int unsigned B3     = FOLD_B3,
    parameter int unsigned PMAX   = PHASE_MAX
) (
    input  logic [PHASE_W-1:0] phase,
    output quadrant_t          quadrant,
    output logic [ADDR_W-1:0]  addr,
    output logic               err
);

    localparam logic [PHASE_W-1:0] P_B1   = PHASE_W'(B1);
    localparam logic [PHASE_W-1:0] P_B2   = PHASE_W'(B2);
    localparam logic [PHASE_W-1:0] P_B3   = PHASE_W'(B3);
    localparam logic [PHASE_W-1:0] P_MAX  = PHASE_W'(PMAX);
    localparam logic [PHASE_W-1:0] P_LAST = PHASE_W'(B1 - 1);

    logic [PHASE_W-1:0] idx;

    // Quadrant select, in-quadrant index and mirrored address for odd quadrants
    always_comb begin
        quadrant = QD0;
        idx      = '0;
        err      = 1'b0;
        addr     = '0;
        if (phase >= P_MAX) begin
            err = 1'b1;
        end else if (phase < P_B1) begin
            quadrant = QD0;
            idx      = phase;
        end else if (phase < P_B2) begin
            quadrant = QD1;
            idx      = phase - P_B1;
        end else if (phase < P_B3) begin
            quadrant = QD2;
            idx      = phase - P_B2;
        end else begin
            quadrant = QD3;
            idx      = phase - P_B3;
        end
        if (!err) begin
            case (quadrant)
                QD1, QD3: addr = ADDR_W'(P_LAST - idx);
                default:  addr = ADDR_W'(idx);
            endcase
        end
    end

endmodule

// File: rtl/sin_lut_arbiter.sv
// Round-robin share of one quarter-wave sine ROM between two phase requesters.
module sin_lut_arbiter
    import sin_lut_pkg::*;
#(
    parameter int unsigned QW_DEPTH = sin_lut_pkg::QW_DEPTH,
    parameter int unsigned ADDR_W   = 11,
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned OFFSET   = sin_lut_pkg::OFFSET
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req0_valid,
    input  logic [PHASE_W-1:0] req0_phase,
    output logic               req0_ready,
    input  logic               req1_valid,
    input  logic [PHASE_W-1:0] req1_phase,
    output logic               req1_ready,
    output logic [ADDR_W-1:0]  lut_addr,
    input  logic [DATA_W-1:0]  lut_q,
    output logic               rsp_valid,
    output logic               rsp_id,
    output logic               rsp_err,
    output logic [DATA_W:0]    rsp_data
);

    localparam logic [DATA_W:0] OFF_EXT = (DATA_W+1)'(OFFSET);

    logic               prio;
    logic               grant0;
    logic               grant1;
    logic [PHASE_W-1:0] gnt_phase;

    quadrant_t          f_qd;
    logic [ADDR_W-1:0]  f_addr;
    logic               f_err;

    logic               s1_valid, s1_id, s1_err;
    quadrant_t          s1_qd;
    logic               s2_valid, s2_id, s2_err;
    quadrant_t          s2_qd;

    logic [DATA_W:0]    q_ext;
    logic [DATA_W:0]    sample;

    // Grant decision: favoured requester wins a tie, nobody is granted in reset
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (!rst) begin
            if (req0_valid && (!req1_valid || !prio))
                grant0 = 1'b1;
            else if (req1_valid)
                grant1 = 1'b1;
        end
        gnt_phase = grant1 ? req1_phase : req0_phase;
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    phase_fold #(
        .ADDR_W (ADDR_W),
        .B1     (QW_DEPTH),
        .B2     (2 * QW_DEPTH),
        .B3     (3 * QW_DEPTH),
        .PMAX   (4 * QW_DEPTH)
    ) u_fold (
        .phase    (gnt_phase),
        .quadrant (f_qd),
        .addr     (f_addr),
        .err      (f_err)
    );

    // Priority pointer moves to the other requester after every grant
    always_ff @(posedge clk) begin
        if (rst)
            prio <= 1'b0;
        else if (grant0)
            prio <= 1'b1;
        else if (grant1)
            prio <= 1'b0;
    end

    // Stage 1: register ROM address alongside the side-band of the grant
    always_ff @(posedge clk) begin
        if (rst) begin
            lut_addr <= '0;
            s1_valid <= 1'b0;
            s1_id    <= 1'b0;
            s1_err   <= 1'b0;
            s1_qd    <= QD0;
        end else begin
            s1_valid <= grant0 | grant1;
            if (grant0 | grant1) begin
                lut_addr <= f_addr;
                s1_id    <= grant1;
                s1_err   <= f_err;
                s1_qd    <= f_qd;
            end
        end
    end

    // Stage 2: side-band waits while the ROM presents its data
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid <= 1'b0;
            s2_id    <= 1'b0;
            s2_err   <= 1'b0;
            s2_qd    <= QD0;
        end else begin
            s2_valid <= s1_valid;
            s2_id    <= s1_id;
            s2_err   <= s1_err;
            s2_qd    <= s1_qd;
        end
    end

    // Sign stage: lower half-circle subtracts from midscale
    always_comb begin
        q_ext = {1'b0, lut_q};
        if (s2_err)
            sample = OFF_EXT;
        else if (s2_qd == QD2 || s2_qd == QD3)
            sample = OFF_EXT - q_ext;
        else
            sample = OFF_EXT + q_ext;
    end

    // Response register; payload holds while no response is issued
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_id    <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_data  <= '0;
        end else begin
            rsp_valid <= s2_valid;
            if (s2_valid) begin
                rsp_id   <= s2_id;
                rsp_err  <= s2_err;
                rsp_data <= sample;
            end
        end
    end

endmodule

// File: tb/tb_sin_lut_arbiter.sv
// Self-checking bench for sin_lut_arbiter with a q = 4*addr ROM model.
module tb_sin_lut_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0_valid = 1'b0;
    logic [11:0] req0_phase = '0;
    logic        req0_ready;
    logic        req1_valid = 1'b0;
    logic [11:0] req1_phase = '0;
    logic        req1_ready;
    logic [10:0] lut_addr;
    logic [15:0] lut_q;
    logic        rsp_valid;
    logic        rsp_id;
    logic        rsp_err;
    logic [16:0] rsp_data;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int id;
        int phase;
        int addr;
        int data;
        int err;
    } vec_t;

    typedef struct {
        int due;
        int id;
        int data;
        int err;
    } exp_rsp_t;

    vec_t     vecs[10];
    exp_rsp_t exp_q[$];

    sin_lut_arbiter #(
        .QW_DEPTH (900),
        .ADDR_W   (11),
        .DATA_W   (16),
        .OFFSET   (16384)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_phase (req0_phase),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_phase (req1_phase),
        .req1_ready (req1_ready),
        .lut_addr   (lut_addr),
        .lut_q      (lut_q),
        .rsp_valid  (rsp_valid),
        .rsp_id     (rsp_id),
        .rsp_err    (rsp_err),
        .rsp_data   (rsp_data)
    );

    always #5 clk = ~clk;

    // ROM model: registered address, q = 4*addr
    always_ff @(posedge clk) lut_q <= {3'b000, lut_addr, 2'b00};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: sample from full-circle phase using quadrant arithmetic
    function automatic void ref_model(input int p, output int addr, output int data, output int err);
        int qd;
        int idx;
        if (p >= 3600) begin
            addr = 0;
            data = 16384;
            err  = 1;
        end else begin
            qd   = p / 900;
            idx  = p % 900;
            addr = (qd % 2 == 1) ? (899 - idx) : idx;
            data = (qd < 2) ? (16384 + 4 * addr) : (16384 - 4 * addr);
            err  = 0;
        end
    endfunction

    task automatic do_reset();
        rst        = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int a, d, e;
        int mprio;
        int cyc;
        bit pend0, pend1, g0, g1, addr_chk;
        int ph0, ph1, exp_addr;
        exp_rsp_t r;

        vecs[0] = '{0, 0,    0,   16384, 0};
        vecs[1] = '{1, 899,  899, 19980, 0};
        vecs[2] = '{1, 900,  899, 19980, 0};
        vecs[3] = '{0, 1800, 0,   16384, 0};
        vecs[4] = '{1, 2705, 894, 12808, 0};
        vecs[5] = '{0, 3600, 0,   16384, 1};
        vecs[6] = '{1, 3599, 0,   16384, 0};
        vecs[7] = '{0, 2699, 899, 12788, 0};
        vecs[8] = '{0, 1799, 0,   16384, 0};
        vecs[9] = '{1, 450,  450, 18184, 0};

        // Reset state, with a requester pending during reset
        rst = 1'b1;
        tick();
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        tick();
        check("rst_ready0", 32'(req0_ready), 32'd0);
        check("rst_ready1", 32'(req1_ready), 32'd0);
        check("rst_lut_addr", 32'(lut_addr), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_id", 32'(rsp_id), 32'd0);
        check("rst_rsp_err", 32'(rsp_err), 32'd0);
        check("rst_rsp_data", 32'(rsp_data), 32'd0);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rst = 1'b0;
        tick();

        // Table: isolated single-requester transactions
        for (int i = 0; i < 10; i++) begin
            if (vecs[i].id == 0) begin
                req0_valid = 1'b1;
                req0_phase = 12'(vecs[i].phase);
            end else begin
                req1_valid = 1'b1;
                req1_phase = 12'(vecs[i].phase);
            end
            #1;
            check("tbl_ready0", 32'(req0_ready), 32'(vecs[i].id == 0));
            check("tbl_ready1", 32'(req1_ready), 32'(vecs[i].id == 1));
            tick();
            req0_valid = 1'b0;
            req1_valid = 1'b0;
            check("tbl_lut_addr", 32'(lut_addr), 32'(vecs[i].addr));
            check("tbl_early_valid", 32'(rsp_valid), 32'd0);
            tick();
            check("tbl_early_valid2", 32'(rsp_valid), 32'd0);
            tick();
            check("tbl_rsp_valid", 32'(rsp_valid), 32'd1);
            check("tbl_rsp_id", 32'(rsp_id), 32'(vecs[i].id));
            check("tbl_rsp_data", 32'(rsp_data), 32'(vecs[i].data));
            check("tbl_rsp_err", 32'(rsp_err), 32'(vecs[i].err));
            tick();
            check("tbl_strobe_end", 32'(rsp_valid), 32'd0);
            check("tbl_data_hold", 32'(rsp_data), 32'(vecs[i].data));
        end

        // Requester 1 back-to-back 899, 900: consecutive responses
        req1_valid = 1'b1;
        req1_phase = 12'd899;
        #1;
        check("b2b_ready_a", 32'(req1_ready), 32'd1);
        tick();
        req1_phase = 12'd900;
        #1;
        check("b2b_ready_b", 32'(req1_ready), 32'd1);
        check("b2b_addr_a", 32'(lut_addr), 32'd899);
        tick();
        req1_valid = 1'b0;
        check("b2b_addr_b", 32'(lut_addr), 32'd899);
        tick();
        check("b2b_rsp_valid_a", 32'(rsp_valid), 32'd1);
        check("b2b_rsp_data_a", 32'(rsp_data), 32'd19980);
        check("b2b_rsp_id_a", 32'(rsp_id), 32'd1);
        tick();
        check("b2b_rsp_valid_b", 32'(rsp_valid), 32'd1);
        check("b2b_rsp_data_b", 32'(rsp_data), 32'd19980);
        check("b2b_rsp_id_b", 32'(rsp_id), 32'd1);
        tick();
        check("b2b_rsp_end", 32'(rsp_valid), 32'd0);

        // Both valid for 6 cycles from reset: alternating grants 0,1,...
        do_reset();
        req0_phase = 12'd100;
        req1_phase = 12'd2000;
        for (int k = 0; k < 10; k++) begin
            req0_valid = (k < 6);
            req1_valid = (k < 6);
            #1;
            if (k < 6) begin
                check("rr_ready0", 32'(req0_ready), 32'(k % 2 == 0));
                check("rr_ready1", 32'(req1_ready), 32'(k % 2 == 1));
            end
            if (k >= 3 && k < 9) begin
                ref_model(((k - 3) % 2 == 0) ? 100 : 2000, a, d, e);
                check("rr_rsp_valid", 32'(rsp_valid), 32'd1);
                check("rr_rsp_id", 32'(rsp_id), 32'((k - 3) % 2));
                check("rr_rsp_data", 32'(rsp_data), 32'(d));
            end else begin
                check("rr_rsp_idle", 32'(rsp_valid), 32'd0);
            end
            tick();
        end

        // Reset with two grants in flight
        req0_valid = 1'b1;
        req0_phase = 12'd1000;
        #1;
        check("mid_ready0", 32'(req0_ready), 32'd1);
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b1;
        req1_phase = 12'd2000;
        #1;
        check("mid_ready1", 32'(req1_ready), 32'd1);
        tick();
        req1_valid = 1'b0;
        req0_valid = 1'b1;
        rst = 1'b1;
        #1;
        check("mid_rst_ready0", 32'(req0_ready), 32'd0);
        check("mid_rst_ready1", 32'(req1_ready), 32'd0);
        tick();
        rst = 1'b0;
        req0_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            check("mid_no_rsp", 32'(rsp_valid), 32'd0);
            tick();
        end
        check("mid_lut_addr", 32'(lut_addr), 32'd0);
        check("mid_rsp_id", 32'(rsp_id), 32'd0);
        check("mid_rsp_err", 32'(rsp_err), 32'd0);
        check("mid_rsp_data", 32'(rsp_data), 32'd0);
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        #1;
        check("mid_next_ready0", 32'(req0_ready), 32'd1);
        check("mid_next_ready1", 32'(req1_ready), 32'd0);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        do_reset();

        // Randomized traffic against the reference model
        mprio    = 0;
        cyc      = 0;
        pend0    = 0;
        pend1    = 0;
        ph0      = 0;
        ph1      = 0;
        addr_chk = 0;
        exp_addr = 0;
        for (int t = 0; t < 500; t++) begin
            if (t < 490 && !pend0) begin
                pend0 = ($urandom_range(0, 2) != 0);
                ph0   = int'($urandom_range(0, 3700));
            end
            if (t < 490 && !pend1) begin
                pend1 = ($urandom_range(0, 2) != 0);
                ph1   = int'($urandom_range(0, 3700));
            end
            req0_valid = pend0;
            req0_phase = 12'(ph0);
            req1_valid = pend1;
            req1_phase = 12'(ph1);
            #1;
            g0 = pend0 && (!pend1 || mprio == 0);
            g1 = pend1 && !g0;
            check("rnd_ready0", 32'(req0_ready), 32'(g0));
            check("rnd_ready1", 32'(req1_ready), 32'(g1));
            if (addr_chk)
                check("rnd_lut_addr", 32'(lut_addr), 32'(exp_addr));
            if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
                r = exp_q.pop_front();
                check("rnd_rsp_valid", 32'(rsp_valid), 32'd1);
                check("rnd_rsp_id", 32'(rsp_id), 32'(r.id));
                check("rnd_rsp_data", 32'(rsp_data), 32'(r.data));
                check("rnd_rsp_err", 32'(rsp_err), 32'(r.err));
            end else begin
                check("rnd_rsp_idle", 32'(rsp_valid), 32'd0);
            end
            addr_chk = g0 || g1;
            if (g0 || g1) begin
                ref_model(g0 ? ph0 : ph1, a, d, e);
                exp_addr = a;
                exp_q.push_back('{cyc + 3, (g1 ? 1 : 0), d, e});
                mprio = g0 ? 1 : 0;
                if (g0) pend0 = 0;
                else    pend1 = 0;
            end
            tick();
            cyc++;
        end
        check("rnd_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sin_lut_arbiter.md
# sin_lut_arbiter

Shares one quarter-wave sine ROM (`sin_lut`, 900 × 16-bit, registered address) between two requesters. Each requester issues a full-circle phase index. The block round-robin arbitrates, folds the phase into quadrant plus ROM address, drives the ROM, and returns a 17-bit offset-binary sample tagged with the requester ID. It sits between the DDS/channel generators and the single `sin_lut` instance, which the parent instantiates.

## Interface
- `QW_DEPTH`, 900: ROM entries per quadrant; valid phase range is 0 .. 4*QW_DEPTH-1.
- `ADDR_W`, 11: ROM address width.
- `DATA_W`, 16: ROM data width; the sample is DATA_W+1 bits.
- `OFFSET`, 16384: midscale added to or subtracted from the ROM value.
- `clk` in 1: single clock. All logic is on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req0_valid` in 1: requester 0 has a phase pending.
- `req0_phase` in 12: requester 0 phase index.
- `req0_ready` out 1: requester 0 is granted this cycle.
- `req1_valid`, `req1_phase`, `req1_ready`: same signals for requester 1.
- `lut_addr` out ADDR_W: registered address to `sin_lut.address`.
- `lut_q` in DATA_W: `sin_lut.q`, valid one cycle after `lut_addr` is captured.
- `rsp_valid` out 1: response strobe, one cycle wide.
- `rsp_id` out 1: requester of this response.
- `rsp_err` out 1: the phase was out of range.
- `rsp_data` out DATA_W+1: offset-binary sine sample.

## Operation
- **Handshake:** a transfer happens when `reqN_valid && reqN_ready`. `reqN_ready` is combinational from both valids and the priority pointer. At most one grant per cycle. A requester holds valid and phase stable until it is granted.
- **Round-robin:**
  - 1-bit pointer `prio`; reset value 0 (favours requester 0).
  - Both valid: the favoured requester is granted, then `prio` moves to the other.
  - Exactly one valid: that requester is granted, then `prio` moves to the other.
  - None valid: `prio` holds.
- **Fold**, on the granted phase p:
  - quadrant qd = 0 if p < 900; 1 if p < 1800; 2 if p < 2700; 3 if p < 3600.
  - idx = p − 900·qd.
  - addr = idx for qd 0 and 2; addr = 899 − idx for qd 1 and 3.
- **Sign:**
  - qd 0 and 1: `rsp_data` = OFFSET + q.
  - qd 2 and 3: `rsp_data` = OFFSET − q.
  - Arithmetic is modulo 2^17. ROM contents are ≤ 16383 by construction, so there is no overflow.
- **Out of range (p ≥ 3600):** the request is accepted. `lut_addr` is driven to 0, `rsp_err`=1 and `rsp_data`=OFFSET.
- **Side-band pipeline:** qd, err and id are carried alongside the ROM access in a 2-stage pipeline.
- **Responses:**
  - No backpressure; the consumer must take every `rsp_valid`.
  - Responses return in grant order.
  - When `rsp_valid`=0, `rsp_data`, `rsp_id` and `rsp_err` hold their last values.

## Timing
- Grant sampled at the end of cycle N:
  - `lut_addr` is valid in N+1.
  - The ROM captures the address at the end of N+1; `lut_q` is valid in N+2.
  - `rsp_*` is registered at the end of N+2; `rsp_valid`=1 in N+3.
- Latency is 3 cycles. Throughput is 1 request per cycle, sustained with both requesters continuously valid (alternating grants 0,1,0,1…).
- Reset values: `lut_addr`=0, `rsp_valid`=0, `rsp_id`=0, `rsp_err`=0, `rsp_data`=0, `prio`=0. The side-band pipeline valids are cleared.
- `req0_ready` and `req1_ready` are 0 whenever `rst`=1.
- Reset mid-operation: all in-flight accesses are discarded. No `rsp_valid` is produced for grants made before the reset edge.
- Single requester continuously valid: granted every cycle.

## Structure
- Package `sin_lut_pkg` holds:
  - `QW_DEPTH`, `PHASE_MAX` (=3600), `OFFSET`.
  - The 2-bit quadrant typedef.
  - The fold boundary constants 900, 1800 and 2700.
- Sub-module `phase_fold` is purely combinational: phase in, {quadrant, addr, err} out.
- The arbiter, pipeline and sign stage live in `sin_lut_arbiter`.
- The ROM stays outside the block.

## Test plan
The bench ROM model returns q = 4·addr, registered address, 1-cycle read.
- Requester 0 only, phase 0 → `lut_addr`=0; in N+3: `rsp_valid`=1, `rsp_id`=0, `rsp_data`=16384.
- Requester 1 only, phases 899 then 900 on consecutive cycles → both map to addr 899; responses 19980, 19980 in consecutive cycles, `rsp_id`=1.
- Phases 1800 and 2705 → addr 0 gives 16384; addr 894 gives 16384−3576 = 12808.
- Both requesters held valid for 6 cycles from reset → grants 0,1,0,1,0,1; `rsp_id` sequence matches with 3-cycle lag.
- Phase 3600 → accepted, `lut_addr`=0, `rsp_err`=1, `rsp_data`=16384.
- Two grants in flight, `rst` pulsed for 1 cycle → no `rsp_valid` afterwards. All outputs are 0, and the next grant goes to requester 0.
